// File: rtl/bcd_pkg.sv
// Shared BCD types, digit constants and elaboration helpers for the BCD counter.
package bcd_pkg;

    localparam int unsigned MAX_DIGITS = 8;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Packs a decimal integer into MAX_DIGITS BCD nibbles, digit 0 in bits [3:0].
    function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int unsigned value);
        logic [4*MAX_DIGITS-1:0] r;
        int unsigned             v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < int'(n); i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit cell: synchronous load, ripple increment/decrement, carry/borrow out.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic       i_load,
    input  bcd_digit_t i_load_val,
    output bcd_digit_t o_q,
    output logic       o_carry_c,
    output logic       o_borrow_c
);

    bcd_digit_t r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= BCD_MIN;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_inc) begin
            r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
        end else if (i_dec) begin
            r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
        end
    end

    assign o_q        = r_q;
    assign o_carry_c  = i_inc && (r_q == BCD_MAX);
    assign o_borrow_c = i_dec && (r_q == BCD_MIN);

endmodule

// File: rtl/segment7.sv
// BCD to 7-segment decoder, active-high, bit 0 = segment a .. bit 6 = segment g.
module segment7 (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_c
);

    always_comb begin
        o_seg_c = 7'h00;
        case (i_bcd)
            4'd0:    o_seg_c = 7'h3F;
            4'd1:    o_seg_c = 7'h06;
            4'd2:    o_seg_c = 7'h5B;
            4'd3:    o_seg_c = 7'h4F;
            4'd4:    o_seg_c = 7'h66;
            4'd5:    o_seg_c = 7'h6D;
            4'd6:    o_seg_c = 7'h7D;
            4'd7:    o_seg_c = 7'h07;
            4'd8:    o_seg_c = 7'h7F;
            4'd9:    o_seg_c = 7'h6F;
            default: o_seg_c = 7'h00;
        endcase
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit native BCD up/down counter with prescaler strobe, programmable limit,
// wrap/saturate boundaries, validated parallel load and per-digit 7-segment outputs.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DIV       = 50_000_000,
    parameter int unsigned LIMIT     = 9999,
    parameter int unsigned WRAP      = 1,
    parameter int unsigned SEGMENTOS = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          direction,
    input  logic                          load,
    input  logic [4*DIGITS-1:0]           load_value,
    output logic [4*DIGITS-1:0]           count_bcd,
    output logic [SEGMENTOS*DIGITS-1:0]   segments,
    output logic                          terminal,
    output logic                          load_error
);

    localparam int unsigned CW = 4 * DIGITS;
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LIMIT_BCD = CW'(int_to_bcd(LIMIT));

    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("DIGITS must be in 1..8");
    end
    if (LIMIT >= pow10(DIGITS)) begin : g_bad_limit
        $error("LIMIT must be below 10^DIGITS");
    end
    if (DIV < 1) begin : g_bad_div
        $error("DIV must be at least 1");
    end
    if (SEGMENTOS < 7) begin : g_bad_seg
        $error("SEGMENTOS must be at least 7");
    end

    logic [PW-1:0]   r_presc;
    logic            r_terminal;
    logic            r_load_error;

    logic            w_tick;
    logic            w_step;
    logic            w_nibbles_ok;
    logic            w_load_ok;
    logic            w_at_limit;
    logic            w_at_zero;
    logic            w_boundary;
    logic            w_dig_load;
    logic [CW-1:0]   w_dig_val;
    logic [CW-1:0]   w_count;
    logic [DIGITS:0] w_carry;
    logic [DIGITS:0] w_borrow;
    logic            w_unused_ovf;

    assign w_tick = enable && (r_presc == PW'(DIV - 1));
    // A load edge (accepted or rejected) swallows any coincident tick.
    assign w_step = w_tick && !load;

    always_comb begin
        w_nibbles_ok = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_value[i*4 +: 4] > BCD_MAX) w_nibbles_ok = 1'b0;
        end
    end

    // With every nibble valid, packed BCD order matches numeric order.
    assign w_load_ok  = w_nibbles_ok && (load_value <= LIMIT_BCD);
    assign w_at_limit = (w_count == LIMIT_BCD);
    assign w_at_zero  = (w_count == '0);
    assign w_boundary = direction ? w_at_limit : w_at_zero;

    // Wrapping at a boundary reuses the digit load path.
    assign w_dig_load = (load && w_load_ok) || (w_step && w_boundary && (WRAP != 0));
    assign w_dig_val  = load ? load_value : (direction ? '0 : LIMIT_BCD);

    assign w_carry[0]  = w_step && direction && !w_at_limit;
    assign w_borrow[0] = w_step && !direction && !w_at_zero;

    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .i_inc      (w_carry[i]),
            .i_dec      (w_borrow[i]),
            .i_load     (w_dig_load),
            .i_load_val (w_dig_val[i*4 +: 4]),
            .o_q        (w_count[i*4 +: 4]),
            .o_carry_c  (w_carry[i+1]),
            .o_borrow_c (w_borrow[i+1])
        );

        logic [6:0] w_seg;

        segment7 u_seg (
            .i_bcd   (w_count[i*4 +: 4]),
            .o_seg_c (w_seg)
        );

        assign segments[i*SEGMENTOS +: SEGMENTOS] = SEGMENTOS'(w_seg);
    end

    // Top-digit carry/borrow never fires: the LIMIT/zero compare blocks the step first.
    assign w_unused_ovf = w_carry[DIGITS] | w_borrow[DIGITS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc      <= '0;
            r_terminal   <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_terminal   <= w_step && w_boundary;
            r_load_error <= load && !w_load_ok;
            if (load) begin
                if (w_load_ok) r_presc <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
            end else if (enable) begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign count_bcd  = w_count;
    assign terminal   = r_terminal;
    assign load_error = r_load_error;

endmodule
